// File: rtl/axi_10g_tx_pkt_fifo_if.sv
// AXI4-Stream link (64-bit data, byte keep, last, user) used on both sides of
// the 10G transmit packet FIFO.
interface axi_10g_tx_pkt_fifo_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axi_10g_tx_pkt_fifo.sv
// Store-and-forward packet FIFO feeding the 10G MAC transmitter: frames are released only once
// complete, bad/overflowing frames are discarded. Optional counters under TX_PKT_FIFO_STATS_EN.
module axi_10g_tx_pkt_fifo #(
  parameter int ADDR_W         = 9,
  parameter int ALMOST_FULL_TH = 480
) (
  input  logic                         clk156,
  input  logic                         tx_axis_aresetn,
  axi_10g_tx_pkt_fifo_if.slave         s_axis,
  axi_10g_tx_pkt_fifo_if.master        m_axis,
  output logic                         s_axis_afull,
  output logic                         tx_fifo_drop
`ifdef TX_PKT_FIFO_STATS_EN
  ,
  input  logic                         stat_clear,
  output logic [31:0]                  stat_frames_out,
  output logic [31:0]                  stat_frames_drop
`endif
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam int          PW    = ADDR_W + 1;
  localparam logic [31:0] AF_TH = 32'(ALMOST_FULL_TH);

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_state_t;

  logic [PW-1:0] r_wr_ptr, r_wr_commit, r_rd_ptr, r_raddr, r_frame_cnt;
  logic          r_ready, r_drop, r_drop_pulse;
  beat_t         r_mem [DEPTH];
  beat_t         r_ram_q, r_out, r_skid;
  logic          r_pend, r_out_valid, r_skid_valid;
  rd_state_t     r_state, w_state_nxt;

  logic [PW-1:0] w_occ, w_frame_cnt_nxt;
  logic [1:0]    w_inflight;
  logic          w_full, w_acc, w_bad, w_wr_en, w_commit;
  logic          w_hs, w_out_last_hs, w_rd_issue;

  assign w_occ    = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_occ == PW'(DEPTH));
  assign w_acc    = s_axis.tvalid & r_ready;
  // A tlast beat that cannot be stored, or that closes a poisoned frame, discards the whole frame.
  assign w_bad    = w_acc & s_axis.tlast & (r_drop | s_axis.tuser | w_full);
  assign w_wr_en  = w_acc & ~w_full & ~r_drop & ~(s_axis.tlast & s_axis.tuser);
  assign w_commit = w_acc & s_axis.tlast & ~w_bad;

  assign w_hs            = r_out_valid & m_axis.tready;
  assign w_out_last_hs   = w_hs & r_out.last;
  assign w_frame_cnt_nxt = r_frame_cnt + PW'(w_commit) - PW'(w_out_last_hs);

  // Beats held in the output/skid registers plus the one in flight from the RAM never exceed two.
  assign w_inflight = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_pend) - 2'(w_hs);
  assign w_rd_issue = (r_state != RD_IDLE) & (r_raddr != r_wr_commit) & (w_inflight < 2'd2);

  always_ff @(posedge clk156 or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_ready      <= 1'b0;
      r_wr_ptr     <= '0;
      r_wr_commit  <= '0;
      r_drop       <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_ready      <= 1'b1;
      r_drop_pulse <= w_bad;
      r_frame_cnt  <= w_frame_cnt_nxt;
      if (w_bad) begin
        r_wr_ptr <= r_wr_commit;
        r_drop   <= 1'b0;
      end else begin
        if (w_wr_en)          r_wr_ptr    <= r_wr_ptr + 1'b1;
        if (w_commit)         r_wr_commit <= r_wr_ptr + 1'b1;
        if (w_acc && w_full)  r_drop      <= 1'b1;
      end
    end
  end

  // NOTE: the storage array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk156) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= '{last: s_axis.tlast, keep: s_axis.tkeep, data: s_axis.tdata};
    if (w_rd_issue)
      r_ram_q <= r_mem[r_raddr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk156 or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: next state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE:   if (w_frame_cnt_nxt != '0) w_state_nxt = RD_PRIME;
      RD_PRIME:  w_state_nxt = RD_STREAM;
      RD_STREAM: if (w_out_last_hs)
                   w_state_nxt = (w_frame_cnt_nxt != '0) ? RD_STREAM : RD_IDLE;
      default:   w_state_nxt = RD_IDLE;
    endcase
  end

  // Output register backed by a skid register: RAM data lands in whichever slot is free.
  always_ff @(posedge clk156 or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_raddr      <= '0;
      r_rd_ptr     <= '0;
      r_pend       <= 1'b0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_pend <= w_rd_issue;
      if (w_rd_issue) r_raddr  <= r_raddr + 1'b1;
      if (w_hs)       r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_hs || !r_out_valid) begin
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_valid  <= 1'b1;
          r_skid_valid <= r_pend;
          if (r_pend) r_skid <= r_ram_q;
        end else begin
          r_out_valid <= r_pend;
          if (r_pend) r_out <= r_ram_q;
        end
      end else if (r_pend) begin
        r_skid       <= r_ram_q;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign s_axis.tready = r_ready;
  assign s_axis_afull  = (32'(w_occ) >= AF_TH);
  assign tx_fifo_drop  = r_drop_pulse;
  assign m_axis.tdata  = r_out.data;
  assign m_axis.tkeep  = r_out.keep;
  assign m_axis.tlast  = r_out.last;
  assign m_axis.tuser  = 1'b0;
  assign m_axis.tvalid = r_out_valid;

`ifdef TX_PKT_FIFO_STATS_EN
  logic [31:0] r_stat_frames_out, r_stat_frames_drop;

  always_ff @(posedge clk156 or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_stat_frames_out  <= '0;
      r_stat_frames_drop <= '0;
    end else if (stat_clear) begin
      r_stat_frames_out  <= '0;
      r_stat_frames_drop <= '0;
    end else begin
      if (w_out_last_hs && (r_stat_frames_out != '1))  r_stat_frames_out  <= r_stat_frames_out + 1'b1;
      if (r_drop_pulse && (r_stat_frames_drop != '1))  r_stat_frames_drop <= r_stat_frames_drop + 1'b1;
    end
  end

  assign stat_frames_out  = r_stat_frames_out;
  assign stat_frames_drop = r_stat_frames_drop;
`endif

endmodule

// File: tb/tb_axi_10g_tx_pkt_fifo.sv
// Scoreboard bench for the 10G tx packet FIFO (16-entry build): frame release, back-to-back,
// overflow and bad-frame drops, stalls and mid-frame reset.
module tb_axi_10g_tx_pkt_fifo;
  localparam int ADDR_W = 4;
  localparam int AF_TH  = 12;

  logic clk156 = 1'b0;
  logic tx_axis_aresetn;
  logic s_axis_afull, tx_fifo_drop;
  always #5 clk156 = ~clk156;

  axi_10g_tx_pkt_fifo_if s_if ();
  axi_10g_tx_pkt_fifo_if m_if ();

`ifdef TX_PKT_FIFO_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_frames_out, stat_frames_drop;
`endif

  axi_10g_tx_pkt_fifo #(.ADDR_W(ADDR_W), .ALMOST_FULL_TH(AF_TH)) dut (
    .clk156          (clk156),
    .tx_axis_aresetn (tx_axis_aresetn),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .s_axis_afull    (s_axis_afull),
    .tx_fifo_drop    (tx_fifo_drop)
`ifdef TX_PKT_FIFO_STATS_EN
    ,
    .stat_clear      (stat_clear),
    .stat_frames_out (stat_frames_out),
    .stat_frames_drop(stat_frames_drop)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [72:0] sb [$];
  int   n_drop_seen = 0;
  int   exp_drops = 0;
  logic tmode = 1'b0;
  logic b2b_en = 1'b0;
  logic b2b_seen = 1'b0;
  int   cyc = 0;
  int   last_hs = 0;

  task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Ready pattern for the stall test is 1,0,0,1 repeating.
  initial begin
    logic [3:0] pat;
    int rcyc;
    pat = 4'b1001;
    rcyc = 0;
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk156);
      #1;
      rcyc++;
      m_if.tready = tmode ? pat[rcyc[1:0]] : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, no mid-frame bubbles, drop pulse count.
  initial begin
    logic        in_frame;
    logic        prev_stall;
    logic [72:0] prev_beat, cur, exp;
    in_frame = 1'b0;
    prev_stall = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk156);
      cyc++;
      cur = {m_if.tlast, m_if.tkeep, m_if.tdata};
      if (!tx_axis_aresetn) begin
        in_frame = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (tx_fifo_drop) n_drop_seen++;
        if (prev_stall) begin
          check("stall_valid", 73'(m_if.tvalid), 73'(1));
          check("stall_data", cur, prev_beat);
        end else if (in_frame) begin
          check("no_bubble", 73'(m_if.tvalid), 73'(1));
        end
        if (m_if.tvalid) check("m_tuser", 73'(m_if.tuser), 73'(0));
        if (m_if.tvalid && m_if.tready) begin
          if (sb.size() == 0) begin
            check("sb_extra_beat", 73'(sb.size()), 73'(1));
          end else begin
            exp = sb.pop_front();
            check("beat", cur, exp);
          end
          if (b2b_en) begin
            if (b2b_seen) check("b2b_gap", 73'(cyc - last_hs), 73'(1));
            b2b_seen = 1'b1;
            last_hs = cyc;
          end
          in_frame = ~m_if.tlast;
          prev_stall = 1'b0;
        end else if (m_if.tvalid) begin
          prev_stall = 1'b1;
          prev_beat = cur;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    @(posedge clk156);
    #1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] klast, input logic bad,
                            input logic expect_out, input logic chk_hidden);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      l = (i == n - 1);
      k = l ? klast : 8'hFF;
      if (expect_out) sb.push_back({l, k, d});
      if (chk_hidden) check("hidden_before_tlast", 73'(m_if.tvalid), 73'(0));
      beat(d, k, l, l & bad);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk156);
      #1;
      n++;
    end
    check("drain", 73'(sb.size()), 73'(0));
    idle(4);
  endtask

  initial begin
    logic [4:0]  occ;
    logic [63:0] d;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    tx_axis_aresetn = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    check("rst_mdata", 73'({m_if.tlast, m_if.tkeep, m_if.tdata}), 73'(0));
    check("rst_ctrl", 73'({m_if.tvalid, m_if.tuser, s_if.tready, s_axis_afull, tx_fifo_drop}), 73'(0));
    tx_axis_aresetn = 1'b1;
    #1;
    check("tready_before_edge", 73'(s_if.tready), 73'(0));
    @(posedge clk156);
    #1;
    check("tready_after_edge", 73'(s_if.tready), 73'(1));

    // Single 8-beat frame: hidden until tlast, then visible within 3 cycles of the commit.
    send_frame(8, 8'h0F, 1'b0, 1'b1, 1'b1);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    @(posedge clk156);
    #1;
    @(posedge clk156);
    #1;
    check("first_beat_latency", 73'(m_if.tvalid), 73'(1));
    drain(100);

    // Three back-to-back 2-beat frames must stream without gaps.
    b2b_en = 1'b1;
    b2b_seen = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(2, 8'h3F, 1'b0, 1'b1, 1'b0);
    idle(1);
    drain(100);
    b2b_en = 1'b0;
    check("frame_cnt_zero", 73'(dut.r_frame_cnt), 73'(0));

    // Oversized frame overflows the 16-entry buffer and is dropped; a following frame survives.
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom};
      beat(d, (i == 19) ? 8'h01 : 8'hFF, (i == 19), 1'b0);
      if (i == 10) check("afull_below_th", 73'(s_axis_afull), 73'(0));
      if (i == 11) check("afull_at_th", 73'(s_axis_afull), 73'(1));
      if (i == 15) check("occ_full", 73'(dut.r_wr_ptr - dut.r_rd_ptr), 73'(16));
    end
    exp_drops++;
    idle(2);
    check("afull_after_drop", 73'(s_axis_afull), 73'(0));
    send_frame(4, 8'h07, 1'b0, 1'b1, 1'b0);
    idle(1);
    drain(100);
    check("drops_after_overflow", 73'(n_drop_seen), 73'(exp_drops));

    // Bad frame (tuser on tlast) vanishes and leaves occupancy where it was.
    occ = dut.r_wr_ptr - dut.r_rd_ptr;
    check("occ_before_bad", 73'(occ), 73'(0));
    send_frame(5, 8'hFF, 1'b1, 1'b0, 1'b1);
    idle(4);
    occ = dut.r_wr_ptr - dut.r_rd_ptr;
    check("occ_after_bad", 73'(occ), 73'(0));
    exp_drops++;
    check("drops_after_bad", 73'(n_drop_seen), 73'(exp_drops));

    // Receiver stalls on a 1,0,0,1 pattern.
    tmode = 1'b1;
    send_frame(10, 8'h7F, 1'b0, 1'b1, 1'b0);
    idle(1);
    drain(200);
    tmode = 1'b0;
    idle(2);

    // Reset in the middle of a frame: the partial frame is lost, the next frame goes through.
    send_frame(3, 8'hFF, 1'b0, 1'b0, 1'b0);
    s_if.tvalid = 1'b0;
    tx_axis_aresetn = 1'b0;
    #2;
    check("midrst_mdata", 73'({m_if.tlast, m_if.tkeep, m_if.tdata}), 73'(0));
    check("midrst_ctrl", 73'({m_if.tvalid, m_if.tuser, s_if.tready, s_axis_afull, tx_fifo_drop}), 73'(0));
    repeat (3) @(posedge clk156);
    #1;
    tx_axis_aresetn = 1'b1;
    @(posedge clk156);
    #1;
    check("tready_after_midrst", 73'(s_if.tready), 73'(1));
    send_frame(2, 8'h03, 1'b0, 1'b1, 1'b0);
    idle(1);
    drain(100);
    idle(10);
    check("drops_final", 73'(n_drop_seen), 73'(exp_drops));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
